// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   state_t : arbiter FSM encoding (IDLE, GRANT)
//   clog2   : ceiling log2, minimum 1, used for index and counter widths
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Never returns 0 so a 1-requester or 1-deep counter still gets a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : index that was served most recently
//   winner     : first set request searching from last_grant+1 upward, modulo N_REQ
//   any_req    : high when at least one request is set
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  logic [IW-1:0] cand [N_REQ];
  logic [IW:0]   sum  [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[k] is the requester examined k+1 places after last_grant. The sum
  // is at most 2*N_REQ-1, so one conditional subtract is a full modulo and
  // stays correct for non-power-of-two N_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, last_grant} + (IW+1)'(gi + 1);
      assign cand[gi] = (sum[gi] >= (IW+1)'(N_REQ)) ? IW'(sum[gi] - (IW+1)'(N_REQ))
                                                     : sum[gi][IW-1:0];
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    winner  = '0;
    any_req = |hit;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) winner = cand[k];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
//   clk_wr     : write-domain clock
//   rst        : asynchronous active-low reset
//   req_valid  : per-requester beat valid
//   req_data   : packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   : per-requester last beat of packet
//   req_ready  : per-requester beat accepted this cycle
//   fifo_full  : FIFO full flag
//   fifo_en_wr : FIFO write enable
//   fifo_din   : FIFO write data
//   grant_id   : currently granted requester
//   busy       : high while a requester holds the grant
// A grant is held until the requester's last beat or MAX_BURST accepted
// beats, whichever comes first; IDLE costs one arbitration cycle.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                        clk_wr,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_en_wr,
  output logic [DATA_WIDTH-1:0]       fifo_din,
  output logic [clog2(N_REQ)-1:0]     grant_id,
  output logic                        busy
);

  localparam int GW = clog2(N_REQ);
  localparam int CW = clog2(MAX_BURST + 1);

  state_t        state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] last_reg,  last_next;
  logic [CW-1:0] cnt_reg,   cnt_next;

  logic [GW-1:0]         winner;
  logic                  any_req;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  burst_end;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (GW)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_reg),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign sel_valid = req_valid[grant_reg];
  assign sel_last  = req_last[grant_reg];
  assign sel_data  = req_data[grant_reg*DATA_WIDTH +: DATA_WIDTH];

  assign busy       = (state_reg == GRANT);
  assign accept     = busy & sel_valid & ~fifo_full;
  assign fifo_en_wr = accept;
  assign fifo_din   = accept ? sel_data : '0;
  assign grant_id   = grant_reg;

  // Ready is offered to the grant holder whenever the FIFO has room,
  // independent of its own valid.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = busy & ~fifo_full & (grant_reg == GW'(gi));
    end
  endgenerate

  // This beat is the MAX_BURST-th of the grant.
  assign burst_end = (cnt_reg == CW'(MAX_BURST - 1));

  always_ff @(posedge clk_wr or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= GW'(N_REQ - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = GRANT;
          grant_next = winner;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (sel_last || burst_end) begin
            state_next = IDLE;
            last_next  = grant_reg;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
